dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bus: core port, external (loader/debug) port and memory port.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          e_req;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_lock;
  logic          e_gnt;
  logic [DW-1:0] e_rdata;
  logic          e_rvalid;

  logic [AW-1:0] m_addr;
  logic          m_wren;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, e_req, e_we, e_addr, e_wdata, e_lock, m_rdata,
    output c_rdata, c_stall, e_gnt, e_rdata, e_rvalid, m_addr, m_wren, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, e_req, e_we, e_addr, e_wdata, e_lock, m_rdata,
    input  c_rdata, c_stall, e_gnt, e_rdata, e_rvalid, m_addr, m_wren, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has fixed priority, external master may lock bursts.
// Optional anti-starvation forced external grant is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int            BW        = $clog2(LOCK_MAX + 1);
  localparam logic [BW-1:0] LOCK_LAST = BW'(LOCK_MAX);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [BW-1:0] beat_r;
  logic [BW-1:0] beat_nxt_s;
  logic          core_gnt_s;
  logic          ext_gnt_s;
  logic          force_ext_s;

  logic [AW-1:0] m_addr_s;
  logic [DW-1:0] m_wdata_s;
  logic          m_wren_s;
  logic          c_stall_s;
  logic          e_gnt_s;
  logic [DW-1:0] e_rdata_r;
  logic          e_rvalid_r;

`ifdef DMEM_ARB_STARVE_EN
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_r;
  logic [SW-1:0] starve_nxt_s;

  assign force_ext_s = (state_r == ARB) && (starve_r == STARVE_TOP);

  // Starvation counter next value: counts core wins over a waiting external master
  always_comb begin
    starve_nxt_s = starve_r;
    if (ext_gnt_s || !bus.e_req) begin
      starve_nxt_s = {SW{1'b0}};
    end else if ((state_r == ARB) && core_gnt_s && (starve_r != STARVE_TOP)) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Starvation counter register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_r <= {SW{1'b0}};
    end else begin
      starve_r <= starve_nxt_s;
    end
  end
`else
  assign force_ext_s = 1'b0;
`endif

  // Ownership decision and next-state logic
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    core_gnt_s  = 1'b0;
    ext_gnt_s   = 1'b0;
    if (RESET) begin
      state_nxt_s = ARB;
      beat_nxt_s  = {BW{1'b0}};
    end else begin
      case (state_r)
        ARB: begin
          state_nxt_s = ARB;
          beat_nxt_s  = {BW{1'b0}};
          if (force_ext_s && bus.e_req) begin
            // forced beat is a single grant; it never opens a locked burst
            ext_gnt_s = 1'b1;
          end else if (bus.c_req) begin
            core_gnt_s = 1'b1;
          end else if (bus.e_req) begin
            ext_gnt_s = 1'b1;
            if (bus.e_lock && (LOCK_LAST > BW'(1))) begin
              state_nxt_s = LOCK;
              beat_nxt_s  = BW'(1);
            end else begin
              state_nxt_s = ARB;
            end
          end else begin
            core_gnt_s = 1'b0;
          end
        end
        LOCK: begin
          if (bus.e_req && bus.e_lock) begin
            ext_gnt_s  = 1'b1;
            beat_nxt_s = beat_r + BW'(1);
            if ((beat_r + BW'(1)) >= LOCK_LAST) begin
              state_nxt_s = ARB;
              beat_nxt_s  = {BW{1'b0}};
            end else begin
              state_nxt_s = LOCK;
            end
          end else begin
            // lock released: this cycle falls back to plain core-priority arbitration
            core_gnt_s  = bus.c_req;
            ext_gnt_s   = !bus.c_req && bus.e_req;
            state_nxt_s = ARB;
            beat_nxt_s  = {BW{1'b0}};
          end
        end
        default: begin
          state_nxt_s = ARB;
          beat_nxt_s  = {BW{1'b0}};
        end
      endcase
    end
  end

  // FSM state and beat counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ARB;
      beat_r  <= {BW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
    end
  end

  // Memory port steering; an ungranted core write never reaches m_wren
  always_comb begin
    m_addr_s  = bus.c_addr;
    m_wdata_s = bus.c_wdata;
    m_wren_s  = 1'b0;
    c_stall_s = 1'b0;
    e_gnt_s   = 1'b0;
    if (ext_gnt_s) begin
      m_addr_s  = bus.e_addr;
      m_wdata_s = bus.e_wdata;
      m_wren_s  = bus.e_we;
      c_stall_s = bus.c_req;
      e_gnt_s   = 1'b1;
    end else if (core_gnt_s) begin
      m_wren_s  = bus.c_we;
    end else begin
      m_wren_s  = 1'b0;
    end
  end

  // External read data capture, valid the cycle after the granted read
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      e_rdata_r  <= {DW{1'b0}};
      e_rvalid_r <= 1'b0;
    end else if (ext_gnt_s && !bus.e_we) begin
      e_rdata_r  <= bus.m_rdata;
      e_rvalid_r <= 1'b1;
    end else begin
      e_rvalid_r <= 1'b0;
    end
  end

  assign bus.m_addr   = m_addr_s;
  assign bus.m_wdata  = m_wdata_s;
  assign bus.m_wren   = m_wren_s;
  assign bus.c_stall  = c_stall_s;
  assign bus.c_rdata  = bus.m_rdata;
  assign bus.e_gnt    = e_gnt_s;
  assign bus.e_rdata  = e_rdata_r;
  assign bus.e_rvalid = e_rvalid_r;

endmodule
